// File: rtl/vga_draw_arbiter_pkg.sv
// vga_draw_arbiter_pkg
// Shared constants and types for the VGA rectangle-fill arbiter:
//   - screen size of the 160x120 VGA adapter
//   - requester indices (screen clear, guess pegs, feedback pegs)
//   - arbiter state encoding
//   - 3-bit colour constants
//   - helpers for the round-robin pointer and on-screen clipping
package vga_draw_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int REQ_CLEAR    = 0;
  localparam int REQ_GUESS    = 1;
  localparam int REQ_FEEDBACK = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] color_t;

  localparam color_t BLACK = 3'b000;
  localparam color_t WHITE = 3'b111;
  localparam color_t RED   = 3'b100;
  localparam color_t GREEN = 3'b010;

  // Pointer value after granting a one-hot requester: the one just above it, mod 3.
  function automatic logic [1:0] nextPtr(input logic [2:0] grant);
    logic [1:0] ptr;
    ptr = 2'd0;
    case (grant)
      3'b001:  ptr = 2'd1;
      3'b010:  ptr = 2'd2;
      3'b100:  ptr = 2'd0;
      default: ptr = 2'd0;
    endcase
    return ptr;
  endfunction

  // Counters are wider than the screen, so anything at or past the edge is clipped.
  function automatic logic onScreen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// vga_draw_arbiter_if
// Bundles the requester side and the VGA write port of the draw arbiter.
//   req/req_x/req_y/req_w/req_h/req_color : three packed rectangle requests
//   gnt/done                               : one-hot per-requester pulses
//   busy                                   : arbiter not idle
//   vga_x/vga_y/vga_color/vga_plot         : VGA adapter write port
// master = the requesters/VGA consumer side, slave = the arbiter.
interface vga_draw_arbiter_if;
  import vga_draw_arbiter_pkg::*;

  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [23:0] req_w;
  logic [20:0] req_h;
  logic [8:0]  req_color;

  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  color_t      vga_color;
  logic        vga_plot;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_color,
    input  gnt, done, busy, vga_x, vga_y, vga_color, vga_plot
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_color,
    output gnt, done, busy, vga_x, vga_y, vga_color, vga_plot
  );

endinterface

// File: rtl/vga_draw_arbiter_rr_select3.sv
// rr_select3
// Combinational three-way round-robin selector.
//   req_i   : pending requests
//   ptr_i   : requester with highest priority this round (0..2)
//   grant_o : one-hot winner, searching upward from ptr_i modulo 3; zero if no request
module rr_select3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] grant_o
);

  // Each pointer value fixes a rotated priority order.
  always_comb begin
    grant_o = 3'b000;
    case (ptr_i)
      2'd1: begin
        if (req_i[1])      grant_o = 3'b010;
        else if (req_i[2]) grant_o = 3'b100;
        else if (req_i[0]) grant_o = 3'b001;
      end
      2'd2: begin
        if (req_i[2])      grant_o = 3'b100;
        else if (req_i[0]) grant_o = 3'b001;
        else if (req_i[1]) grant_o = 3'b010;
      end
      default: begin
        if (req_i[0])      grant_o = 3'b001;
        else if (req_i[1]) grant_o = 3'b010;
        else if (req_i[2]) grant_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
// Arbitrates three rectangle-fill requesters onto one VGA adapter write port.
// A granted rectangle is filled one pixel per cycle in raster order; pixels
// outside the 160x120 screen still take a cycle but are not plotted.
//   clk    : system clock
//   resetn : synchronous, active-low reset
//   bus    : request inputs, gnt/done/busy and the VGA write port (slave side)
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  vga_draw_arbiter_if.slave  bus
);

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [2:0]  owner_q;
  logic [2:0]  gnt_q;
  logic [2:0]  done_q;
  logic [7:0]  x0_q;
  logic [7:0]  w_q;
  logic [6:0]  y0_q;
  logic [6:0]  h_q;
  logic [8:0]  curX_q;
  logic [7:0]  curY_q;
  color_t      vgaColor_q;
  logic        vgaPlot_q;

  logic [2:0]  grantVec;
  logic [7:0]  selX;
  logic [6:0]  selY;
  logic [7:0]  selW;
  logic [6:0]  selH;
  color_t      selColor;

  logic [8:0]  xLast;
  logic [7:0]  yLast;
  logic [8:0]  nextX_d;
  logic [7:0]  nextY_d;
  logic        zeroSize;
  logic        lastPixel;

  rr_select3 u_rrSelect (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (grantVec)
  );

  // Pick the winner's rectangle fields out of the packed request buses.
  always_comb begin
    selX     = bus.req_x[8*REQ_CLEAR +: 8];
    selY     = bus.req_y[7*REQ_CLEAR +: 7];
    selW     = bus.req_w[8*REQ_CLEAR +: 8];
    selH     = bus.req_h[7*REQ_CLEAR +: 7];
    selColor = bus.req_color[3*REQ_CLEAR +: 3];
    case (grantVec)
      3'b010: begin
        selX     = bus.req_x[8*REQ_GUESS +: 8];
        selY     = bus.req_y[7*REQ_GUESS +: 7];
        selW     = bus.req_w[8*REQ_GUESS +: 8];
        selH     = bus.req_h[7*REQ_GUESS +: 7];
        selColor = bus.req_color[3*REQ_GUESS +: 3];
      end
      3'b100: begin
        selX     = bus.req_x[8*REQ_FEEDBACK +: 8];
        selY     = bus.req_y[7*REQ_FEEDBACK +: 7];
        selW     = bus.req_w[8*REQ_FEEDBACK +: 8];
        selH     = bus.req_h[7*REQ_FEEDBACK +: 7];
        selColor = bus.req_color[3*REQ_FEEDBACK +: 3];
      end
      default: ;
    endcase
  end

  // Raster stepping. Widened counters keep x0+w-1 / y0+h-1 from wrapping;
  // xLast/yLast are meaningless for a zero-size rectangle, which zeroSize covers.
  always_comb begin
    xLast     = {1'b0, x0_q} + {1'b0, w_q} - 9'd1;
    yLast     = {1'b0, y0_q} + {1'b0, h_q} - 8'd1;
    zeroSize  = (w_q == 8'd0) || (h_q == 7'd0);
    lastPixel = (curX_q == xLast) && (curY_q == yLast);
    if (curX_q == xLast) begin
      nextX_d = {1'b0, x0_q};
      nextY_d = curY_q + 8'd1;
    end else begin
      nextX_d = curX_q + 9'd1;
      nextY_d = curY_q;
    end
  end

  // Control FSM with registered outputs. The grant edge already loads the first
  // pixel, so gnt and the first plot share the first DRAW cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= 3'b000;
      gnt_q      <= 3'b000;
      done_q     <= 3'b000;
      x0_q       <= 8'd0;
      w_q        <= 8'd0;
      y0_q       <= 7'd0;
      h_q        <= 7'd0;
      curX_q     <= 9'd0;
      curY_q     <= 8'd0;
      vgaColor_q <= BLACK;
      vgaPlot_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q     <= 3'b000;
          done_q    <= 3'b000;
          vgaPlot_q <= 1'b0;
          if (grantVec != 3'b000) begin
            state_q    <= DRAW;
            owner_q    <= grantVec;
            gnt_q      <= grantVec;
            ptr_q      <= nextPtr(grantVec);
            x0_q       <= selX;
            w_q        <= selW;
            y0_q       <= selY;
            h_q        <= selH;
            curX_q     <= {1'b0, selX};
            curY_q     <= {1'b0, selY};
            vgaColor_q <= selColor;
            vgaPlot_q  <= (selW != 8'd0) && (selH != 7'd0) &&
                          onScreen({1'b0, selX}, {1'b0, selY});
          end
        end

        DRAW: begin
          gnt_q <= 3'b000;
          if (zeroSize || lastPixel) begin
            state_q   <= DONE;
            done_q    <= owner_q;
            vgaPlot_q <= 1'b0;
          end else begin
            curX_q    <= nextX_d;
            curY_q    <= nextY_d;
            vgaPlot_q <= onScreen(nextX_d, nextY_d);
          end
        end

        DONE: begin
          // Always pass through IDLE so a waiting requester is never granted here.
          state_q   <= IDLE;
          done_q    <= 3'b000;
          vgaPlot_q <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          gnt_q     <= 3'b000;
          done_q    <= 3'b000;
          vgaPlot_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.vga_x     = curX_q[7:0];
  assign bus.vga_y     = curY_q[6:0];
  assign bus.vga_color = vgaColor_q;
  assign bus.vga_plot  = vgaPlot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter
// Directed bench for vga_draw_arbiter: reset values, round-robin order,
// raster fill, clipping, zero-size rectangles, full-screen clear and
// reset in the middle of a fill.
module tb_vga_draw_arbiter;
  import vga_draw_arbiter_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  vga_draw_arbiter_if drawBus ();

  vga_draw_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (drawBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Load one requester's rectangle and raise its request.
  task automatic applyStimulus(input int idx, input logic [7:0] x, input logic [6:0] y,
                               input logic [7:0] w, input logic [6:0] h, input logic [2:0] col);
    drawBus.req_x[8*idx +: 8]     = x;
    drawBus.req_y[7*idx +: 7]     = y;
    drawBus.req_w[8*idx +: 8]     = w;
    drawBus.req_h[7*idx +: 7]     = h;
    drawBus.req_color[3*idx +: 3] = col;
    drawBus.req[idx]              = 1'b1;
  endtask

  // Wait for idx's grant, drop its request, then follow the fill against a raster model.
  task automatic runFill(input int idx, input logic [7:0] x, input logic [6:0] y,
                         input logic [7:0] w, input logic [6:0] h, input logic [2:0] col,
                         input int expDraw, input int expPlots, input int lastX, input int lastY);
    int         waitCnt;
    int         drawCycles;
    int         plots;
    int         seenX;
    int         seenY;
    logic [8:0] ex;
    logic [7:0] ey;
    logic       expPlot;

    waitCnt = 0;
    do begin
      waitCycle();
      waitCnt++;
    end while (drawBus.gnt == 3'b000 && waitCnt < 200);
    checkOutput("gnt", drawBus.gnt, 32'(3'b001 << idx));
    checkOutput("gnt_latency", waitCnt, 1);
    drawBus.req[idx] = 1'b0;

    ex         = {1'b0, x};
    ey         = {1'b0, y};
    drawCycles = 0;
    plots      = 0;
    seenX      = -1;
    seenY      = -1;
    while (drawBus.done == 3'b000 && drawCycles < 20000) begin
      expPlot = (w != 8'd0) && (h != 7'd0) && (ex < 9'd160) && (ey < 8'd120);
      checkOutput("busy_draw", drawBus.busy, 1);
      if (drawCycles > 0) checkOutput("gnt_pulse", drawBus.gnt, 0);
      checkOutput("plot", drawBus.vga_plot, expPlot);
      if (expPlot) begin
        checkOutput("vga_x", drawBus.vga_x, ex);
        checkOutput("vga_y", drawBus.vga_y, ey);
        checkOutput("vga_color", drawBus.vga_color, col);
      end
      if (drawBus.vga_plot) begin
        plots++;
        seenX = drawBus.vga_x;
        seenY = drawBus.vga_y;
      end
      if (ex == {1'b0, x} + {1'b0, w} - 9'd1) begin
        ex = {1'b0, x};
        ey++;
      end else begin
        ex++;
      end
      drawCycles++;
      waitCycle();
    end

    checkOutput("done", drawBus.done, 32'(3'b001 << idx));
    checkOutput("plot_in_done", drawBus.vga_plot, 0);
    checkOutput("busy_in_done", drawBus.busy, 1);
    checkOutput("draw_cycles", drawCycles, expDraw);
    checkOutput("plot_count", plots, expPlots);
    if (expPlots > 0) begin
      checkOutput("last_x", seenX, lastX);
      checkOutput("last_y", seenY, lastY);
    end

    waitCycle();
    checkOutput("done_pulse", drawBus.done, 0);
    checkOutput("busy_idle", drawBus.busy, 0);
    checkOutput("no_grant_from_done", drawBus.gnt, 0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    resetn            = 1'b0;
    drawBus.req       = 3'b000;
    drawBus.req_x     = '0;
    drawBus.req_y     = '0;
    drawBus.req_w     = '0;
    drawBus.req_h     = '0;
    drawBus.req_color = '0;

    // All three requesters held from reset.
    applyStimulus(0, 8'd10, 7'd20, 8'd2, 7'd1, RED);
    applyStimulus(1, 8'd30, 7'd40, 8'd1, 7'd2, WHITE);
    applyStimulus(2, 8'd50, 7'd60, 8'd1, 7'd1, GREEN);
    waitCycle();
    waitCycle();
    checkOutput("rst_gnt", drawBus.gnt, 0);
    checkOutput("rst_done", drawBus.done, 0);
    checkOutput("rst_busy", drawBus.busy, 0);
    checkOutput("rst_plot", drawBus.vga_plot, 0);
    checkOutput("rst_x", drawBus.vga_x, 0);
    checkOutput("rst_y", drawBus.vga_y, 0);
    checkOutput("rst_color", drawBus.vga_color, 0);
    resetn = 1'b1;

    // Contention, first round: order 0, 1, 2.
    runFill(0, 8'd10, 7'd20, 8'd2, 7'd1, RED,   2, 2, 11, 20);
    runFill(1, 8'd30, 7'd40, 8'd1, 7'd2, WHITE, 2, 2, 30, 41);
    runFill(2, 8'd50, 7'd60, 8'd1, 7'd1, GREEN, 1, 1, 50, 60);

    // Second round after re-raising all three: pointer wrapped, order 0, 1, 2 again.
    applyStimulus(0, 8'd10, 7'd20, 8'd2, 7'd1, RED);
    applyStimulus(1, 8'd30, 7'd40, 8'd1, 7'd2, WHITE);
    applyStimulus(2, 8'd50, 7'd60, 8'd1, 7'd1, GREEN);
    runFill(0, 8'd10, 7'd20, 8'd2, 7'd1, RED,   2, 2, 11, 20);
    runFill(1, 8'd30, 7'd40, 8'd1, 7'd2, WHITE, 2, 2, 30, 41);
    runFill(2, 8'd50, 7'd60, 8'd1, 7'd1, GREEN, 1, 1, 50, 60);

    // Pointer at 1 after serving 0: requests 0 and 2 together must grant 2 first.
    applyStimulus(0, 8'd1, 7'd2, 8'd1, 7'd1, WHITE);
    runFill(0, 8'd1, 7'd2, 8'd1, 7'd1, WHITE, 1, 1, 1, 2);
    applyStimulus(0, 8'd3, 7'd4, 8'd1, 7'd1, RED);
    applyStimulus(2, 8'd5, 7'd6, 8'd2, 7'd1, GREEN);
    runFill(2, 8'd5, 7'd6, 8'd2, 7'd1, GREEN, 2, 2, 6, 6);
    runFill(0, 8'd3, 7'd4, 8'd1, 7'd1, RED,   1, 1, 3, 4);

    // Single request, 4x4 at (128,10).
    applyStimulus(2, 8'd128, 7'd10, 8'd4, 7'd4, BLACK);
    runFill(2, 8'd128, 7'd10, 8'd4, 7'd4, BLACK, 16, 16, 131, 13);

    // Clipping at the bottom-right corner.
    applyStimulus(1, 8'd158, 7'd118, 8'd4, 7'd4, GREEN);
    runFill(1, 8'd158, 7'd118, 8'd4, 7'd4, GREEN, 16, 4, 159, 119);

    // Zero width.
    applyStimulus(1, 8'd40, 7'd40, 8'd0, 7'd5, RED);
    runFill(1, 8'd40, 7'd40, 8'd0, 7'd5, RED, 1, 0, 0, 0);

    // Full-screen clear.
    applyStimulus(0, 8'd0, 7'd0, 8'd160, 7'd120, WHITE);
    runFill(0, 8'd0, 7'd0, 8'd160, 7'd120, WHITE, 19200, 19200, 159, 119);

    // Reset after 5 pixels of a 4x4 fill at (20,30).
    applyStimulus(2, 8'd20, 7'd30, 8'd4, 7'd4, WHITE);
    waitCycle();
    checkOutput("mid_gnt", drawBus.gnt, 3'b100);
    drawBus.req[2] = 1'b0;
    checkOutput("mid_first_x", drawBus.vga_x, 20);
    repeat (4) waitCycle();
    checkOutput("mid_fifth_plot", drawBus.vga_plot, 1);
    checkOutput("mid_fifth_x", drawBus.vga_x, 20);
    checkOutput("mid_fifth_y", drawBus.vga_y, 31);
    resetn = 1'b0;
    waitCycle();
    checkOutput("mid_rst_gnt", drawBus.gnt, 0);
    checkOutput("mid_rst_done", drawBus.done, 0);
    checkOutput("mid_rst_busy", drawBus.busy, 0);
    checkOutput("mid_rst_plot", drawBus.vga_plot, 0);
    checkOutput("mid_rst_x", drawBus.vga_x, 0);
    checkOutput("mid_rst_y", drawBus.vga_y, 0);
    checkOutput("mid_rst_color", drawBus.vga_color, 0);
    waitCycle();
    checkOutput("mid_rst_no_done", drawBus.done, 0);
    resetn = 1'b1;
    applyStimulus(1, 8'd5, 7'd5, 8'd3, 7'd2, RED);
    runFill(1, 8'd5, 7'd5, 8'd3, 7'd2, RED, 6, 6, 7, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port req, input, 3 bits: per-requester draw request (0 = screen clear, 1 = guess pegs, 2 = feedback pegs).
REQ-004 The block SHALL have port req_x, input, 24 bits: three 8-bit rectangle origin x values, requester i in bits [8i+7:8i].
REQ-005 The block SHALL have port req_y, input, 21 bits: three 7-bit origin y values, requester i in bits [7i+6:7i].
REQ-006 The block SHALL have port req_w, input, 24 bits: three 8-bit widths in pixels.
REQ-007 The block SHALL have port req_h, input, 21 bits: three 7-bit heights in pixels.
REQ-008 The block SHALL have port req_color, input, 9 bits: three 3-bit fill colours.
REQ-009 The block SHALL have port gnt, output, 3 bits: one-hot, one-cycle pulse when that requester's rectangle is accepted.
REQ-010 The block SHALL have port done, output, 3 bits: one-hot, one-cycle pulse when that requester's fill completes.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have ports vga_x (output, 8 bits), vga_y (output, 7 bits), vga_color (output, 3 bits) and vga_plot (output, 1 bit), all registered, forming the VGA adapter write port.

Function
REQ-013 The block SHALL implement the states IDLE, DRAW and DONE.
REQ-014 In IDLE, on a clock edge with req != 0, the block SHALL grant the round-robin winner, latch its x/y/w/h/colour, and enter DRAW.
REQ-015 The round-robin order SHALL search from the priority pointer upward, modulo 3; after granting requester i, the pointer SHALL become (i+1) mod 3.
REQ-016 gnt[i] SHALL be high only in the first DRAW cycle.
REQ-017 The first pixel SHALL appear in that same cycle, giving a latency of 1 cycle from req sampled to first vga_plot.
REQ-018 In DRAW, the block SHALL emit one pixel per cycle in raster order: x from x0 to x0+w-1, then y+1, until y0+h-1, for exactly w*h DRAW cycles.
REQ-019 vga_color SHALL equal the latched colour for every pixel of the fill.
REQ-020 The coordinate counters SHALL be 9-bit (x) and 8-bit (y) internally, so x0+w and y0+h do not wrap.
REQ-021 A pixel with x > 159 or y > 119 SHALL be clipped: vga_plot = 0 for that pixel, but the cycle is still consumed.
REQ-022 If w = 0 or h = 0, the block SHALL spend one DRAW cycle with vga_plot = 0 (gnt still pulses), then go to DONE.
REQ-023 In DONE, done[i] SHALL be high for one cycle, vga_plot SHALL be 0, and the next state SHALL be IDLE, with no back-to-back grant from DONE.
REQ-024 Requests arriving during DRAW or DONE SHALL wait; a requester SHALL hold req until gnt.
REQ-025 A req dropped before gnt SHALL be treated as withdrawn, with no grant.
REQ-026 Requester inputs other than req SHALL be ignored outside the grant edge.
REQ-027 A req still high after done SHALL be re-arbitrated as a new request.
REQ-028 When multiple requests arrive simultaneously, exactly one grant SHALL be issued per arbitration edge.

Reset
REQ-029 While resetn = 0 at a clock edge, the block SHALL set: state = IDLE, pointer = 0, gnt = 0, done = 0, busy = 0, vga_plot = 0, vga_x = 0, vga_y = 0, vga_color = 0.
REQ-030 Reset mid-DRAW SHALL abort the fill: no done pulse, and the remaining pixels are never plotted.

Structure
REQ-031 A shared package SHALL hold the screen constants SCREEN_W = 160 and SCREEN_H = 120, requester indices REQ_CLEAR = 0, REQ_GUESS = 1 and REQ_FEEDBACK = 2, the state encoding, and the colour constants BLACK = 000, WHITE = 111, RED = 100 and GREEN = 010.
REQ-032 The round-robin selector SHALL be one sub-module, rr_select3: inputs req[2:0] and ptr[1:0]; output one-hot grant; combinational.

Verification
REQ-033 The bench SHALL cover single request: req = 3'b100, x0 = 128, y0 = 10, w = 4, h = 4, colour = 000 -> gnt[2] pulses, 16 plots (128..131, 10..13) in raster order, done[2] one cycle after the last plot.
REQ-034 The bench SHALL cover contention: req = 3'b111 held from reset, with each requester dropping on its gnt -> grant order 0, 1, 2; a second round after re-raising all three -> order 0, 1, 2 again (pointer wrapped to 0).
REQ-035 The bench SHALL cover clipping: x0 = 158, y0 = 118, w = 4, h = 4, colour = 010 -> 16 DRAW cycles, only 4 with vga_plot = 1 (x 158..159, y 118..119).
REQ-036 The bench SHALL cover zero size: w = 0, h = 5 -> gnt, 1 DRAW cycle with no plot, done; the complete transaction takes 2 cycles.
REQ-037 The bench SHALL cover full clear: requester 0 with x0 = 0, y0 = 0, w = 160, h = 120 -> 19200 plots, last pixel (159, 119), busy high throughout.
REQ-038 The bench SHALL cover reset mid-fill: resetn = 0 after 5 pixels of a 4x4 fill -> all outputs 0 next cycle, no done, and a following request is served normally.
